// File: rtl/seg_pkg.sv
// Shared types and constants for the 4-digit 7-segment scan driver.
package seg_pkg;

  localparam int unsigned NUM_DIGITS = 4;

  typedef logic [6:0] seg_t;
  typedef logic [1:0] slot_t;

  localparam seg_t                  SEG_OFF = 7'h7F;
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = 4'hF;

  // One complete display image, indexed by scan slot (slot 0 = rightmost digit).
  typedef struct packed {
    seg_t [NUM_DIGITS-1:0]  segs;
    logic [NUM_DIGITS-1:0]  dp;
    logic [NUM_DIGITS-1:0]  en;
  } frame_t;

  localparam frame_t FRAME_OFF = {{NUM_DIGITS{SEG_OFF}}, {NUM_DIGITS{1'b1}}, {NUM_DIGITS{1'b0}}};

endpackage

// File: rtl/scan_prescaler.sv
// Digit-slot timebase: cnt runs 0..REFRESH_DIV-1 per slot, slot walks 0..3.
module scan_prescaler
  import seg_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000,
  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  output logic [CNT_W-1:0] cnt_o,
  output slot_t            slot_o,
  output logic             slot_wrap_c,
  output logic             frame_end_c
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  slot_t            slot_q, slot_d;

  assign slot_wrap_c = (cnt_q == CNT_W'(REFRESH_DIV - 1));
  assign frame_end_c = slot_wrap_c && (slot_q == 2'(NUM_DIGITS - 1));
  assign cnt_o       = cnt_q;
  assign slot_o      = slot_q;

  always_comb begin
    cnt_d  = cnt_q + CNT_W'(1);
    slot_d = slot_q;
    if (slot_wrap_c) begin
      cnt_d  = '0;
      slot_d = slot_q + 2'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      slot_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      slot_q <= slot_d;
    end
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode 4-digit driver with frame-synchronous
// double buffering and per-slot dead time.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned DEAD_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] cx1,
  input  logic [6:0] cx2,
  input  logic [6:0] cx3,
  input  logic [6:0] cx4,
  input  logic [3:0] dp_in,
  input  logic [3:0] digit_en,
  input  logic       load,
  output logic       pending,
  output logic       frame_tick,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [CNT_W-1:0] cnt;
  slot_t            slot;
  logic             slot_wrap_c, frame_end_c, boundary_c;
  frame_t           sample_c;

  frame_t pend_buf_q, pend_buf_d;
  frame_t disp_q, disp_d;
  logic   pending_q, pending_d;
  logic   tick_q, tick_d;
  seg_t   seg_q, seg_d;
  logic   dp_q, dp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;

  scan_prescaler #(.REFRESH_DIV(REFRESH_DIV)) u_prescaler (
    .clk_i       (clk),
    .rst_i       (rst),
    .cnt_o       (cnt),
    .slot_o      (slot),
    .slot_wrap_c (slot_wrap_c),
    .frame_end_c (frame_end_c)
  );

  assign boundary_c = slot_wrap_c & frame_end_c;
  assign sample_c   = {{cx1, cx2, cx3, cx4}, dp_in, digit_en};

  // A load on the boundary cycle lands in the pending buffer after the old contents commit.
  always_comb begin
    pend_buf_d = pend_buf_q;
    pending_d  = pending_q;
    disp_d     = disp_q;
    if (boundary_c) begin
      if (pending_q) disp_d = pend_buf_q;
      pending_d = 1'b0;
    end
    if (load) begin
      pend_buf_d = sample_c;
      pending_d  = 1'b1;
    end
  end

  always_comb begin
    seg_d  = SEG_OFF;
    dp_d   = 1'b1;
    an_d   = AN_OFF;
    tick_d = boundary_c;
    if ((cnt >= CNT_W'(DEAD_CYCLES)) && disp_q.en[slot]) begin
      an_d  = ~(4'b0001 << slot);
      seg_d = disp_q.segs[slot];
      dp_d  = disp_q.dp[slot];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_buf_q <= FRAME_OFF;
      disp_q     <= FRAME_OFF;
      pending_q  <= 1'b0;
      tick_q     <= 1'b0;
      seg_q      <= SEG_OFF;
      dp_q       <= 1'b1;
      an_q       <= AN_OFF;
    end else begin
      pend_buf_q <= pend_buf_d;
      disp_q     <= disp_d;
      pending_q  <= pending_d;
      tick_q     <= tick_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      an_q       <= an_d;
    end
  end

  assign pending    = pending_q;
  assign frame_tick = tick_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with an 8-cycle slot and 2-cycle dead time.
module tb_seg_scan_driver;

  localparam int unsigned RDIV  = 8;
  localparam int unsigned DEAD  = 2;
  localparam int unsigned FRAME = 4 * RDIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] cx1 = 7'h00, cx2 = 7'h00, cx3 = 7'h00, cx4 = 7'h00;
  logic [3:0] dp_in = 4'h0, digit_en = 4'h0;
  logic       load = 1'b0;
  logic       pending, frame_tick, dp;
  logic [6:0] seg;
  logic [3:0] an;

  int n_cmp = 0;
  int n_err = 0;
  int k     = 0;

  logic [6:0] exp_seg [4];
  logic [3:0] exp_dp, exp_en;
  logic       exp_pend;

  seg_scan_driver #(.REFRESH_DIV(RDIV), .DEAD_CYCLES(DEAD)) dut (
    .clk        (clk),
    .rst        (rst),
    .cx1        (cx1),
    .cx2        (cx2),
    .cx3        (cx3),
    .cx4        (cx4),
    .dp_in      (dp_in),
    .digit_en   (digit_en),
    .load       (load),
    .pending    (pending),
    .frame_tick (frame_tick),
    .seg        (seg),
    .dp         (dp),
    .an         (an)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s k=%0d got=%h expected=%h", tag, k, got, want);
    end
  endtask

  task automatic set_disp(input logic [6:0] c1, input logic [6:0] c2, input logic [6:0] c3,
                          input logic [6:0] c4, input logic [3:0] dpv, input logic [3:0] env);
    exp_seg[3] = c1;
    exp_seg[2] = c2;
    exp_seg[1] = c3;
    exp_seg[0] = c4;
    exp_dp     = dpv;
    exp_en     = env;
  endtask

  // Step n clocks; output after edge k reflects the counter phase k-1.
  task automatic cyc_check(input int n);
    int         p;
    logic [1:0] s;
    logic [3:0] w_an;
    logic [6:0] w_seg;
    logic       w_dp;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      k++;
      #1;
      p     = k - 1;
      s     = 2'((p / RDIV) % 4);
      w_an  = 4'hF;
      w_seg = 7'h7F;
      w_dp  = 1'b1;
      if ((p % RDIV) >= DEAD && exp_en[s]) begin
        w_an  = ~(4'b0001 << s);
        w_seg = exp_seg[s];
        w_dp  = exp_dp[s];
      end
      check_eq("an", 32'(an), 32'(w_an));
      check_eq("seg", 32'(seg), 32'(w_seg));
      check_eq("dp", 32'(dp), 32'(w_dp));
      check_eq("frame_tick", 32'(frame_tick), 32'((k % FRAME) == 0));
      check_eq("pending", 32'(pending), 32'(exp_pend));
    end
  endtask

  task automatic run_to(input int target);
    cyc_check(target - k);
  endtask

  task automatic do_load(input logic [6:0] c1, input logic [6:0] c2, input logic [6:0] c3,
                         input logic [6:0] c4, input logic [3:0] dpv, input logic [3:0] env);
    cx1 = c1; cx2 = c2; cx3 = c3; cx4 = c4;
    dp_in = dpv; digit_en = env;
    load = 1'b1;
    exp_pend = 1'b1;
    cyc_check(1);
    load = 1'b0;
    cx1 = 7'h00; cx2 = 7'h00; cx3 = 7'h00; cx4 = 7'h00;
    dp_in = 4'h0; digit_en = 4'h0;
  endtask

  task automatic check_reset_outs(input string tag);
    check_eq({tag, "_seg"}, 32'(seg), 32'h7F);
    check_eq({tag, "_an"}, 32'(an), 32'hF);
    check_eq({tag, "_dp"}, 32'(dp), 32'h1);
    check_eq({tag, "_pending"}, 32'(pending), 32'h0);
    check_eq({tag, "_frame_tick"}, 32'(frame_tick), 32'h0);
  endtask

  initial begin
    set_disp(7'h7F, 7'h7F, 7'h7F, 7'h7F, 4'hF, 4'h0);
    exp_pend = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outs("reset");
    rst = 1'b0;
    k   = 0;

    // Idle: blank display, frame_tick every 32 cycles
    run_to(64);

    // Load 7'h79/24/30/19, commit at the frame boundary
    do_load(7'h79, 7'h24, 7'h30, 7'h19, 4'hF, 4'hF);
    run_to(95);
    exp_pend = 1'b0;
    cyc_check(1);
    set_disp(7'h79, 7'h24, 7'h30, 7'h19, 4'hF, 4'hF);
    run_to(128);

    // Two loads in one frame: last wins, 7'h40 never shown
    run_to(130);
    do_load(7'h40, 7'h40, 7'h40, 7'h40, 4'hF, 4'hF);
    run_to(140);
    do_load(7'h12, 7'h12, 7'h12, 7'h12, 4'b1010, 4'hF);
    run_to(159);
    exp_pend = 1'b0;
    cyc_check(1);
    set_disp(7'h12, 7'h12, 7'h12, 7'h12, 4'b1010, 4'hF);

    // Load on the boundary cycle: old pending commits, new one waits a frame
    run_to(170);
    do_load(7'h06, 7'h5B, 7'h4F, 7'h66, 4'b0110, 4'hF);
    run_to(191);
    do_load(7'h2F, 7'h0C, 7'h47, 7'h21, 4'b1001, 4'hF);
    set_disp(7'h06, 7'h5B, 7'h4F, 7'h66, 4'b0110, 4'hF);
    run_to(223);
    exp_pend = 1'b0;
    cyc_check(1);
    set_disp(7'h2F, 7'h0C, 7'h47, 7'h21, 4'b1001, 4'hF);
    run_to(256);

    // Partial enable: slots 1 and 3 stay dark, frame period unchanged
    do_load(7'h08, 7'h03, 7'h46, 7'h0E, 4'h0, 4'b0101);
    run_to(287);
    exp_pend = 1'b0;
    cyc_check(1);
    set_disp(7'h08, 7'h03, 7'h46, 7'h0E, 4'h0, 4'b0101);
    run_to(320);

    // Reset mid-slot 2 with a pending load discards everything
    run_to(329);
    do_load(7'h00, 7'h00, 7'h00, 7'h00, 4'h0, 4'hF);
    run_to(339);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outs("midreset");
    rst = 1'b0;
    k   = 0;
    exp_pend = 1'b0;
    set_disp(7'h7F, 7'h7F, 7'h7F, 7'h7F, 4'hF, 4'h0);
    run_to(40);
    do_load(7'h1C, 7'h2A, 7'h55, 7'h63, 4'b1100, 4'hF);
    run_to(63);
    exp_pend = 1'b0;
    cyc_check(1);
    set_disp(7'h1C, 7'h2A, 7'h55, 7'h63, 4'b1100, 4'hF);
    run_to(96);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
